// File: rtl/cube_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cube_sched_pkg
// Brief    : Shared types and width helpers for the cube multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package cube_sched_pkg;

    localparam int C_NREQ = 4;
    localparam int C_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_CUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cube_mul_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cube_mul_sched_if
// Brief    : Request/response bundle between requesters and the cube scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface cube_mul_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    import cube_sched_pkg::*;

    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [3*W-1:0]    rsp_c;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_c, busy
    );

    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_c, busy
    );

endinterface
`default_nettype wire

// File: rtl/cube_mul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Requester arbiter; round-robin when CUBE_SCHED_RR_EN is defined,
//            otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cube_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_w(NREQ)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic            i_advance,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_idx,
    output logic                 o_any
);

`ifdef CUBE_SCHED_RR_EN
    logic [IDW-1:0] r_ptr;

    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ptr <= IDW'(NREQ - 1);
        else if (i_advance) r_ptr <= o_idx;
    end

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!o_any && i_req[(int'(r_ptr) + k) % NREQ]) begin
                o_any = 1'b1;
                o_idx = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_advance};

    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDW'(i);
        end
    end
`endif

    assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/cube_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : cube_mul_sched
// Brief    : Shares one registered cube datapath (square, multiply, sign fix)
//            among NREQ requesters. Macro CUBE_SCHED_RR_EN selects round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module cube_mul_sched
    import cube_sched_pkg::*;
#(
    parameter int NREQ = C_NREQ,
    parameter int W    = C_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    cube_mul_sched_if.slave bus
);

    localparam int IDW = id_w(NREQ);
    localparam int OW  = 3 * W;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_mag;
    logic            r_neg;
    logic [IDW-1:0]  r_id;
    logic [2*W-1:0]  r_sq;
    logic [OW-1:0]   r_cu;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_accept;
    logic [W-1:0]    w_op;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    assign w_op = bus.req_a[int'(w_idx)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_SQR;
            S_SQR:  w_next = S_CUB;
            S_CUB:  w_next = S_DONE;
            S_DONE: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ready is held low while reset is asserted, even if requests are pending.
    always_comb begin
        w_accept      = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.busy      = 1'b0;
                w_accept      = w_any & rst_n;
                bus.req_ready = w_accept ? w_grant : '0;
            end
            S_DONE:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // The most negative operand negates to 2^(W-1), which still fits W unsigned bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_neg <= 1'b0;
            r_id  <= '0;
            r_sq  <= '0;
            r_cu  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_mag <= w_op[W-1] ? (~w_op + 1'b1) : w_op;
                    r_neg <= w_op[W-1];
                    r_id  <= w_idx;
                end
                S_SQR:   r_sq <= (2*W)'(r_mag) * (2*W)'(r_mag);
                S_CUB:   r_cu <= OW'(r_sq) * OW'(r_mag);
                default: ;
            endcase
        end
    end

    assign bus.rsp_id = r_id;
    assign bus.rsp_c  = r_neg ? (~r_cu + 1'b1) : r_cu;

endmodule
`default_nettype wire

// File: doc/cube_mul_sched.md
# cube_mul_sched

Sequencer and arbiter that shares one registered cube datapath (square stage, then multiply-by-magnitude stage, then sign fix-up) between NREQ requesters. It accepts one signed operand at a time via valid/ready, steps the datapath through a fixed FSM, and returns the signed cube tagged with the requester index. It sits between the requesting blocks and the shared multiplier resource; no other block drives the multiplier.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width, signed two's complement
- OW, 3*W, result width, signed
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*W  packed operands, requester i at [i*W +: W]
- req_ready  out  NREQ  one-hot accept strobe (at most one bit high)
- rsp_valid  out  1  result valid
- rsp_id  out  $clog2(NREQ)  index of the requester that owns rsp_c
- rsp_c  out  OW  signed cube of the accepted operand
- rsp_ready  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SQR, CUB, DONE.
- IDLE: if any req_valid, arbiter picks winner g; req_ready[g]=1 combinationally that cycle; handshake completes; capture mag=|req_a[g]| (W bits unsigned), neg=req_a[g][W-1], id=g; go SQR. No request -> stay IDLE.
- SQR: sq <= mag*mag (2W bits unsigned); go CUB.
- CUB: cu <= sq*mag (3W bits unsigned); go DONE.
- DONE: rsp_valid=1, rsp_c = neg ? -cu : cu, rsp_id=id; all held stable until rsp_ready; on rsp_valid && rsp_ready go IDLE.
- req_ready is 0 in SQR, CUB, DONE; requesters keep valid/operand stable until their ready.
- Width rule: most negative operand -2^(W-1) gives mag=2^(W-1); cube -2^(3W-3) fits OW signed. No overflow possible; no saturation.
- Zero operand: result 0, neg ignored (never -0 issue in two's complement).
- Arbitration: round-robin (see Configuration). Pointer updates only on accept, to g.

## Timing
- Reset (rst low, async): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, busy=0, sq=cu=0, mag=0, neg=0, rr pointer=NREQ-1 (requester 0 has first priority).
- Latency: accept at cycle T -> rsp_valid high at T+3.
- rsp_ready high in the first DONE cycle: IDLE at T+4, next accept earliest T+4; max throughput 1 result / 4 cycles.
- rsp_ready low: DONE held indefinitely, outputs stable, no new accept.
- Reset asserted mid-operation (any state): in-flight request discarded, no response issued, outputs to reset values immediately.
- req_valid dropped before ready: no capture, no state change.

## Configuration
- CUBE_SCHED_RR_EN defined: round-robin; search starts at pointer+1 modulo NREQ, winner becomes new pointer.
- CUBE_SCHED_RR_EN undefined: fixed priority, lowest asserted index wins; pointer logic removed.

## Structure
- Package cube_sched_pkg: state enum (IDLE, SQR, CUB, DONE), default width constants, id width function.
- Sub-module rr_arbiter (NREQ-wide request in, one-hot grant + encoded index out, pointer register, advance strobe); macro only affects this module.
- Datapath registers (mag, neg, id, sq, cu) stay in cube_mul_sched.

## Test plan
- Single request: req 1, a=3, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_c=27, rsp_id=1.
- Negative/boundary: a=-8 -> rsp_c=12'hE00 (-512); a=-2 -> 12'hFF8 (-8); a=7 -> 343; a=0 -> 0.
- Contention: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 (RR_EN); without macro grants 0,0,0.
- Backpressure: rsp_ready low 10 cycles in DONE -> rsp_c/rsp_id stable, all req_ready low, busy high; accept resumes 1 cycle after rsp_ready handshake.
- Reset mid-CUB: rst low one cycle -> rsp_valid never asserts for that request, busy=0, next accept goes to requester 0.
- Ready one-hot: random valids 1000 requests -> $onehot0(req_ready) always, each result matches a^3 for its id.
